// File: rtl/des_round_sequencer.sv
// ---------------------------------------------------------------------------
// des_round_sequencer
//   Control FSM for an iterative DES core. Accepts a block/key job through a
//   valid/ready handshake, then drives the datapath strobes: one LOAD cycle,
//   ROUNDS Feistel-round cycles with per-round key-schedule rotate controls,
//   one FINAL cycle, and then holds out_valid until the consumer accepts.
//   No data bits live here; all 64-bit state is in the datapath.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   start_valid / start_ready  job request handshake
//   decrypt                    mode, latched on accept (1 = decrypt)
//   abort                      synchronous flush to IDLE
//   load_en                    datapath loads IP(block), PC-1(key)
//   round_en, round_idx        one Feistel round this cycle, 0-based index
//   key_shift_en/_two/_dir     C/D rotate enable, by-two, direction (1=right)
//   final_en                   datapath captures FP(R,L)
//   out_valid / out_ready      result handshake
//   busy                       FSM not in IDLE
// ---------------------------------------------------------------------------
module des_round_sequencer #(
    parameter int ROUNDS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       decrypt,
    input  logic       abort,
    output logic       load_en,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic       key_shift_en,
    output logic       key_shift_two,
    output logic       key_shift_dir,
    output logic       final_en,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_e;

    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

    // Bit i set when the encrypt rotate amount for round i is 2.
    // Shift table 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (round 0 in bit 0).
    localparam logic [15:0] ENC_TWO = 16'b0111_1110_1111_1100;

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       mode_q, mode_d;

    logic       accept;
    logic [3:0] dec_sel;

    // Handshake: ready is the only output allowed to see live inputs.
    always_comb begin
        start_ready = ~abort & rst_n &
                      ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
        accept      = start_valid & start_ready;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOAD;
                    mode_d  = decrypt;
                end
            end
            S_LOAD: begin
                state_d = S_ROUND;
                idx_d   = 4'd0;
            end
            S_ROUND: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINAL;
                    idx_d   = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_FINAL: state_d = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = S_LOAD;
                        mode_d  = decrypt;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
            end
        endcase
        // Abort wins over everything, including a DONE handshake.
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    // Decrypt walks the encrypt table backwards: round i uses S[16-i].
    // 4-bit wrap of 0-i gives 16-i for i>=1; round 0 does not rotate.
    assign dec_sel = 4'd0 - idx_q;

    // Moore output decode. Everything is forced low while rst_n is held so a
    // mid-job reset never lets a strobe through during the reset cycle.
    always_comb begin
        load_en       = 1'b0;
        round_en      = 1'b0;
        final_en      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b0;
        round_idx     = 4'd0;
        key_shift_en  = 1'b0;
        key_shift_two = 1'b0;
        key_shift_dir = 1'b0;
        if (rst_n) begin
            busy      = (state_q != S_IDLE);
            load_en   = (state_q == S_LOAD);
            final_en  = (state_q == S_FINAL);
            out_valid = (state_q == S_DONE);
            round_idx = idx_q;
            if (state_q == S_ROUND) begin
                round_en      = 1'b1;
                key_shift_dir = mode_q;
                if (mode_q) begin
                    key_shift_en  = (idx_q != 4'd0);
                    key_shift_two = (idx_q != 4'd0) & ENC_TWO[dec_sel];
                end else begin
                    key_shift_en  = 1'b1;
                    key_shift_two = ENC_TWO[idx_q];
                end
            end
        end
    end

endmodule

// File: tb/tb_des_round_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for des_round_sequencer: per-cycle vector tables for a full encrypt
// and decrypt job (ROUNDS=16), hand sequences for backpressure, abort and
// mid-job reset, and a short table for a ROUNDS=1 instance.
// Inputs are driven just after the falling edge and outputs compared 1ns
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_des_round_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start_valid, decrypt, abort, out_ready;
    logic       start_ready, load_en, round_en, key_shift_en, key_shift_two;
    logic       key_shift_dir, final_en, out_valid, busy;
    logic [3:0] round_idx;

    logic       r1_sv, r1_ory;
    logic       r1_sr, r1_ld, r1_rd, r1_ken, r1_k2, r1_kd, r1_fin, r1_ov, r1_busy;
    logic [3:0] r1_idx;

    des_round_sequencer #(.ROUNDS(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid),
        .start_ready(start_ready), .decrypt(decrypt), .abort(abort),
        .load_en(load_en), .round_en(round_en), .round_idx(round_idx),
        .key_shift_en(key_shift_en), .key_shift_two(key_shift_two),
        .key_shift_dir(key_shift_dir), .final_en(final_en),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    des_round_sequencer #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_valid(r1_sv),
        .start_ready(r1_sr), .decrypt(1'b0), .abort(1'b0),
        .load_en(r1_ld), .round_en(r1_rd), .round_idx(r1_idx),
        .key_shift_en(r1_ken), .key_shift_two(r1_k2),
        .key_shift_dir(r1_kd), .final_en(r1_fin),
        .out_valid(r1_ov), .out_ready(r1_ory), .busy(r1_busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {start_ready, busy, load, round, final, out_valid, ken, ktwo, kdir, idx}
    function automatic logic [12:0] E(input logic sr, bz, ld, rd, fn, ov,
                                      ke, k2, kd, input logic [3:0] ix);
        return {sr, bz, ld, rd, fn, ov, ke, k2, kd, ix};
    endfunction

    function automatic logic [12:0] outs();
        return {start_ready, busy, load_en, round_en, final_en, out_valid,
                key_shift_en, key_shift_two, key_shift_dir, round_idx};
    endfunction

    function automatic logic [12:0] outs1();
        return {r1_sr, r1_busy, r1_ld, r1_rd, r1_fin, r1_ov,
                r1_ken, r1_k2, r1_kd, r1_idx};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        string       name;
        logic        rst, sv, dec, ab, ory;
        logic [12:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input string n, input logic rst, sv, dec, ab, ory,
                       input logic [12:0] e);
        vec_t v;
        v.name = n; v.rst = rst; v.sv = sv; v.dec = dec; v.ab = ab; v.ory = ory;
        v.exp = e;
        tbl.push_back(v);
    endtask

    // Applies the table; returns total rotate amount seen on the key controls.
    task automatic run_tbl(output int shift_sum);
        shift_sum = 0;
        foreach (tbl[k]) begin
            @(negedge clk);
            rst_n = tbl[k].rst; start_valid = tbl[k].sv; decrypt = tbl[k].dec;
            abort = tbl[k].ab; out_ready = tbl[k].ory;
            #1;
            chk(tbl[k].name, 32'(outs()), 32'(tbl[k].exp));
            if (key_shift_en) shift_sum += key_shift_two ? 2 : 1;
        end
        tbl.delete();
    endtask

    // Bounded wait: 0 = out_valid, 1 = round_en at round_idx==arg
    task automatic wait_for(input int what, input int arg, input int maxc,
                            input string name);
        bit hit = 0;
        for (int n = 0; n < maxc && !hit; n++) begin
            @(negedge clk); #1;
            if (what == 0) hit = out_valid;
            else           hit = round_en && (round_idx == 4'(arg));
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL %s: timeout after %0d cycles, expected event", name, maxc);
        end
    endtask

    logic [15:0] two_pat;
    int          sum, t_acc, t_ld;
    bit          seen;

    initial begin
        rst_n = 0; start_valid = 0; decrypt = 0; abort = 0; out_ready = 1;
        r1_sv = 0; r1_ory = 1;
        // Rotate-by-two flags, round 0 in bit 0, same sequence for both modes.
        two_pat = 16'b0111_1110_1111_1100;

        // ---- reset + encrypt job ----
        add("rst_low0", 0, 0, 0, 0, 1, E(0,0,0,0,0,0,0,0,0,4'd0));
        add("rst_low1", 0, 1, 0, 0, 1, E(0,0,0,0,0,0,0,0,0,4'd0));
        add("idle",     1, 0, 0, 0, 1, E(1,0,0,0,0,0,0,0,0,4'd0));
        add("enc_acc",  1, 1, 0, 0, 1, E(1,0,0,0,0,0,0,0,0,4'd0));
        add("enc_load", 1, 0, 1, 0, 1, E(0,1,1,0,0,0,0,0,0,4'd0));
        for (int i = 0; i < 16; i++)
            add($sformatf("enc_r%0d", i), 1, 0, 0, 0, 1,
                E(0,1,0,1,0,0,1,two_pat[i],0,4'(i)));
        add("enc_final", 1, 0, 0, 0, 1, E(0,1,0,0,1,0,0,0,0,4'd0));
        add("enc_done",  1, 0, 0, 0, 1, E(1,1,0,0,0,1,0,0,0,4'd0));
        add("enc_idle",  1, 0, 0, 0, 1, E(1,0,0,0,0,0,0,0,0,4'd0));
        run_tbl(sum);
        chk("enc_shift_sum", 32'(sum), 32'd28);

        // ---- decrypt job, decrypt input toggled mid-job ----
        add("dec_acc",  1, 1, 1, 0, 1, E(1,0,0,0,0,0,0,0,0,4'd0));
        add("dec_load", 1, 0, 0, 0, 1, E(0,1,1,0,0,0,0,0,0,4'd0));
        add("dec_r0",   1, 0, 0, 0, 1, E(0,1,0,1,0,0,0,0,1,4'd0));
        for (int i = 1; i < 16; i++)
            add($sformatf("dec_r%0d", i), 1, 0, 1'(i), 0, 1,
                E(0,1,0,1,0,0,1,two_pat[i],1,4'(i)));
        add("dec_final", 1, 0, 0, 0, 1, E(0,1,0,0,1,0,0,0,0,4'd0));
        add("dec_done",  1, 0, 0, 0, 1, E(1,1,0,0,0,1,0,0,0,4'd0));
        add("dec_idle",  1, 0, 0, 0, 1, E(1,0,0,0,0,0,0,0,0,4'd0));
        run_tbl(sum);
        chk("dec_shift_sum", 32'(sum), 32'd27);

        // ---- backpressure, then back-to-back jobs ----
        @(negedge clk); start_valid = 1; decrypt = 0; out_ready = 0; #1;
        t_acc = cyc;
        @(negedge clk); start_valid = 0;
        wait_for(0, 0, 30, "bp_wait_valid");
        chk("bp_latency", 32'(cyc - t_acc), 32'd19);
        for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            start_valid = 1; out_ready = 0; #1;
            chk($sformatf("bp_hold%0d", n),
                32'({out_valid, start_ready, load_en, round_en, final_en, key_shift_en}),
                32'(6'b100000));
        end
        @(negedge clk); start_valid = 1; out_ready = 1; #1;
        chk("bp_accept_ready", 32'({out_valid, start_ready}), 32'(2'b11));
        @(negedge clk); #1;
        chk("bp_load_next", 32'({load_en, out_valid}), 32'(2'b10));
        t_ld = cyc;
        seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk); #1;
            seen = load_en;
        end
        chk("b2b_spacing", 32'(cyc - t_ld), 32'd19);
        start_valid = 0;
        wait_for(0, 0, 30, "b2b_drain");
        @(negedge clk); #1;
        chk("b2b_idle", 32'({busy, start_ready}), 32'(2'b01));

        // ---- abort at round 7 ----
        @(negedge clk); start_valid = 1; decrypt = 0; out_ready = 1;
        @(negedge clk); start_valid = 0;
        wait_for(1, 7, 12, "ab_wait_r7");
        abort = 1; #1;
        chk("ab_ready_low", 32'(start_ready), 32'd0);
        @(negedge clk); abort = 0; #1;
        chk("ab_idle", 32'({busy, round_idx, start_ready, round_en}), 32'({1'b0, 4'd0, 1'b1, 1'b0}));
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            seen |= final_en | out_valid | round_en;
        end
        chk("ab_no_final", 32'(seen), 32'd0);

        // ---- abort in DONE with out_ready=1 and a pending request ----
        @(negedge clk); start_valid = 1; out_ready = 0;
        @(negedge clk); start_valid = 0;
        wait_for(0, 0, 30, "abd_wait_valid");
        start_valid = 1; out_ready = 1; abort = 1; #1;
        chk("abd_ready_low", 32'(start_ready), 32'd0);
        @(negedge clk); abort = 0; start_valid = 0; #1;
        chk("abd_idle", 32'({busy, load_en, out_valid}), 32'd0);

        // ---- reset at round 3 with start_valid high ----
        @(negedge clk); start_valid = 1;
        @(negedge clk); start_valid = 0;
        wait_for(1, 3, 10, "rs_wait_r3");
        rst_n = 0; start_valid = 1; #1;
        chk("rs_during", 32'(outs()), 32'd0);
        @(negedge clk); rst_n = 1; start_valid = 0; #1;
        chk("rs_after", 32'(outs()), 32'(E(1,0,0,0,0,0,0,0,0,4'd0)));
        @(negedge clk); start_valid = 1; #1;
        t_acc = cyc;
        @(negedge clk); start_valid = 0; #1;
        chk("rs_new_load", 32'(load_en), 32'd1);
        wait_for(0, 0, 30, "rs_new_done");
        chk("rs_new_latency", 32'(cyc - t_acc), 32'd19);
        @(negedge clk); #1;
        chk("rs_new_idle", 32'(busy), 32'd0);

        // ---- ROUNDS=1 instance ----
        @(negedge clk); r1_sv = 1; #1;
        chk("r1_acc", 32'(outs1()), 32'(E(1,0,0,0,0,0,0,0,0,4'd0)));
        @(negedge clk); r1_sv = 0; #1;
        chk("r1_load", 32'(outs1()), 32'(E(0,1,1,0,0,0,0,0,0,4'd0)));
        @(negedge clk); #1;
        chk("r1_round", 32'(outs1()), 32'(E(0,1,0,1,0,0,1,0,0,4'd0)));
        @(negedge clk); #1;
        chk("r1_final", 32'(outs1()), 32'(E(0,1,0,0,1,0,0,0,0,4'd0)));
        @(negedge clk); #1;
        chk("r1_done", 32'(outs1()), 32'(E(1,1,0,0,0,1,0,0,0,4'd0)));
        @(negedge clk); #1;
        chk("r1_idle", 32'(outs1()), 32'(E(1,0,0,0,0,0,0,0,0,4'd0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
